uart_tx_frame: RTL

//  UART transmit serializer for the UART-to-APB bridge. It is the transmit-side counterpart of the RX parity checker.
//  - Accepts one parallel byte per handshake.
//  - Emits the frame LSB-first on tx_out: start, DATA_WIDTH data bits, optional parity, stop.
//  - Each bit lasts CLKS_PER_BIT clocks.
//  - Parity polarity matches the RX checker: par_type=1 odd, par_type=0 even.

---
 rtl/uart_tx_frame_pkg.sv | 10 +
 rtl/uart_baud_cnt.sv | 17 +
 rtl/uart_tx_frame.sv | 68 ++++++
 3 files changed

// File: rtl/uart_tx_frame_pkg.sv
// uart_tx_frame_pkg: shared FSM states, parity polarity and line idle level for the UART TX path
package uart_tx_frame_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;
  localparam logic LINE_IDLE = 1'b1;
  function automatic logic par_bit(input logic par_type, input logic xor_red);
    return (par_type == PAR_ODD) ? ~xor_red : xor_red;
  endfunction
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  logic [CW-1:0] cnt;
  assign bit_end = cnt == LAST;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= (clr || bit_end) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: LSB-first UART transmit serializer with optional odd/even parity
module uart_tx_frame
  import uart_tx_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_type,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  tx_done
);
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(DATA_WIDTH - 1);
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] data_q;
  logic [IW-1:0] idx, idx_n;
  logic par_q, par_en_q, bit_end, tx_n;
  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk), .rst(rst), .clr(state == IDLE), .bit_end(bit_end)
  );
  always_comb begin
    state_n = state;
    idx_n = idx;
    unique case (state)
      IDLE:    state_n = data_valid ? START : IDLE;
      START:   state_n = bit_end ? DATA : START;
      DATA: if (bit_end) begin
        idx_n = (idx == LAST) ? '0 : idx + 1'b1;
        state_n = (idx != LAST) ? DATA : par_en_q ? PARITY : STOP;
      end
      PARITY:  state_n = bit_end ? STOP : PARITY;
      STOP:    state_n = bit_end ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
    // outputs are registered, so the line level is derived from the next state
    tx_n = (state_n == START) ? 1'b0 :
           (state_n == DATA) ? data_q[idx_n] :
           (state_n == PARITY) ? par_q : LINE_IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      data_q <= '0;
      par_q <= 1'b0;
      par_en_q <= 1'b0;
      tx_out <= LINE_IDLE;
      busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      if (state == IDLE && data_valid) begin
        data_q <= p_data;
        par_q <= par_bit(par_type, ^p_data);
        par_en_q <= par_en;
      end
      tx_out <= tx_n;
      busy <= state_n != IDLE;
      tx_done <= state == STOP && state_n == IDLE;
    end
endmodule
